blk_xfer_ctrl: RTL and testbench
================================

# blk_xfer_ctrl

Cache-side initiator for the main-memory block port. Accepts one miss-service request at a time from the cache controller (optional dirty-block writeback, optional block fill), and sequences it onto the memory's `addr`/`rd_en`/`wr_en`/`wr_data`/`rd_data` interface. Enables are held for a fixed, parameterised latency. The fill result returns to the cache with a one-cycle response pulse. Writeback always completes before fill, so a fill never reads stale data.

## Interface
- `LATENCY`, 4: cycles each memory operation holds its enable; legal range ≥1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_wb` in 1: perform writeback.
- `req_fill` in 1: perform fill.
- `req_wb_addr` in `PA_WIDTH`: writeback block address.
- `req_fill_addr` in `PA_WIDTH`: fill block address.
- `req_wb_data` in `BLK_WIDTH`: dirty block data.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out `BLK_WIDTH`: last filled block.
- `busy` out 1: high whenever not IDLE.
- `mem_addr` out `PA_WIDTH`: drives memory `addr`.
- `mem_rd_en` out 1: drives memory `rd_en`.
- `mem_wr_en` out 1: drives memory `wr_en`.
- `mem_wr_data` out `BLK_WIDTH`: drives memory `wr_data`.
- `mem_rd_data` in `BLK_WIDTH`: from memory `rd_data`.

## Operation
- **States:** IDLE, WB, FILL, RESP.
- **IDLE:**
  - On accept, latch both addresses, `req_wb_data`, and both flags.
  - Next state is WB if `req_wb`, else FILL if `req_fill`, else RESP.
  - An accept with both flags low still produces a `resp_valid` pulse (ack).
- **WB:**
  - `mem_wr_en`=1, `mem_addr`=latched wb addr, `mem_wr_data`=latched data, for exactly `LATENCY` cycles.
  - Then go to FILL if the fill flag is set, else RESP.
- **FILL:**
  - `mem_rd_en`=1, `mem_addr`=latched fill addr, for `LATENCY` cycles.
  - `mem_rd_data` is captured into `resp_data` on the last FILL cycle.
  - Then go to RESP.
- **RESP:**
  - `resp_valid`=1 for one cycle, then IDLE.
  - `resp_data` changes only on a fill capture; wb-only and empty requests leave it unchanged.
- **Address alignment:** the low `$clog2(BLK_WIDTH/BYTE)` bits of both latched addresses are forced to 0.
- **Enable exclusivity:** `mem_rd_en` and `mem_wr_en` are never high together. Both are low in IDLE and RESP; `mem_addr` and `mem_wr_data` are 0 there.
- **Request inputs while busy:** ignored, since `req_ready`=0. The requester must hold `req_valid` until accepted.
- **Reset values:** all outputs 0 except `req_ready`=1; state IDLE, latency counter 0.
- **Reset mid-operation:** enables drop on the cycle after `rst` is sampled, no `resp_valid` is issued, and the transfer is abandoned.
- **Latency counter:**
  - Width `$clog2(LATENCY+1)`.
  - Loads `LATENCY-1` on entry to WB/FILL, decrements to 0, and must not wrap.
  - Reloads on a WB→FILL transition.

## Timing
- Accept at edge 0.
- Fill only: FILL on cycles 1..L, `resp_valid` on cycle L+1, `req_ready` high again on cycle L+2.
- Writeback + fill: WB on cycles 1..L, FILL on cycles L+1..2L, `resp_valid` on cycle 2L+1.
- Writeback only: `resp_valid` on cycle L+1.
- Empty request: `resp_valid` on cycle 1.
- Back-to-back: a request presented during RESP is accepted only at the IDLE cycle that follows. Minimum spacing is L+2 cycles for fill-only requests.
- `resp_data` is stable from the RESP cycle until the next fill capture.

## Structure
- `PA_WIDTH`, `BLK_WIDTH`, `BYTE`, `WRD_WIDTH` come from `macros.sv`.
- The state enum typedef and the block-offset width constant go in the shared cache package for reuse by the cache controller.
- One sub-module, `lat_counter`: load, decrement, `done` flag, parameterised by `LATENCY`.

## Test plan
- **Reset:** assert `rst` 2 cycles → `req_ready`=1, `busy`=0, both enables 0, `resp_data`=0.
- **Fill only:**
  - Setup: mem instance `INIT=1`, `SEED=0`, LATENCY=4, preload block at 0x0040 with pattern 0xA5.
  - Stimulus: fill 0x0040.
  - Expect: `mem_rd_en` high for cycles 1-4, `resp_valid` at cycle 5, `resp_data`=all 0xA5.
- **Writeback + fill:**
  - Stimulus: wb 0x0080 with data all 0x3C, fill 0x0080.
  - Expect: `mem_wr_en` for cycles 1-4, then `mem_rd_en` for cycles 5-8, `resp_valid` at cycle 9, `resp_data`=all 0x3C.
  - Enables never overlap.
- **Unaligned address:** fill 0x0047 → `mem_addr`=0x0040 throughout FILL.
- **Empty and wb-only:**
  - Empty request → `resp_valid` at cycle 1, `resp_data` unchanged.
  - Wb-only request → `resp_valid` at cycle 5, `resp_data` unchanged.
- **Reset mid-WB:** assert `rst` on cycle 2 of WB → enables 0 the next cycle, no `resp_valid`, `req_ready`=1; a subsequent fill completes normally.

Source files
------------

// File: rtl/blk_xfer_ctrl_pkg.sv
// Shared cache-side definitions: memory geometry, transfer FSM states and
// the block-alignment helper used by the miss-service initiator.
package blk_xfer_ctrl_pkg;

  localparam int PA_WIDTH  = 16;
  localparam int BLK_WIDTH = 64;
  localparam int BYTE      = 8;
  localparam int WRD_WIDTH = 32;

  // Byte-offset bits inside one block; forced to zero on every block address.
  localparam int BLK_OFF_W = $clog2(BLK_WIDTH / BYTE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_FILL = 2'd2,
    ST_RESP = 2'd3
  } xfer_state_e;

  function automatic logic [PA_WIDTH-1:0] blk_align(input logic [PA_WIDTH-1:0] addr);
    return {addr[PA_WIDTH-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/blk_xfer_ctrl_lat_counter.sv
// Saturating down-counter timing how long a memory enable is held.
// done is high while the count sits at zero.
module lat_counter #(
  parameter int LATENCY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic done
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/blk_xfer_ctrl.sv
// Miss-service initiator: optional writeback then optional fill on the
// main-memory block port, finishing with a one-cycle response pulse.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// WB    | mem_wr_en held with latched wb address/data for LATENCY cycles
// FILL  | mem_rd_en held with latched fill address, data captured on last cycle
// RESP  | resp_valid pulse, then back to IDLE
module blk_xfer_ctrl
  import blk_xfer_ctrl_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wb,
  input  logic                 req_fill,
  input  logic [PA_WIDTH-1:0]  req_wb_addr,
  input  logic [PA_WIDTH-1:0]  req_fill_addr,
  input  logic [BLK_WIDTH-1:0] req_wb_data,
  output logic                 resp_valid,
  output logic [BLK_WIDTH-1:0] resp_data,
  output logic                 busy,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_data,
  input  logic [BLK_WIDTH-1:0] mem_rd_data
);

  xfer_state_e state_q, state_d;

  logic                 wb_q, fill_q;
  logic [PA_WIDTH-1:0]  wb_addr_q, fill_addr_q;
  logic [BLK_WIDTH-1:0] wb_data_q;
  logic                 accept, cnt_load, cnt_dec, cnt_done;

  assign accept = req_valid && (state_q == ST_IDLE);

  // Reload on entry to either memory phase, including WB -> FILL.
  assign cnt_load = (accept && (req_wb || req_fill)) ||
                    ((state_q == ST_WB) && cnt_done && fill_q);
  assign cnt_dec  = (state_q == ST_WB) || (state_q == ST_FILL);

  lat_counter #(.LATENCY(LATENCY)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .done (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) state_d = req_wb ? ST_WB : (req_fill ? ST_FILL : ST_RESP);
      ST_WB:   if (cnt_done) state_d = fill_q ? ST_FILL : ST_RESP;
      ST_FILL: if (cnt_done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    resp_valid  = (state_q == ST_RESP);
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if ((state_q == ST_WB) && wb_q) begin
      mem_wr_en   = 1'b1;
      mem_addr    = wb_addr_q;
      mem_wr_data = wb_data_q;
    end else if (state_q == ST_FILL) begin
      mem_rd_en = 1'b1;
      mem_addr  = fill_addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q        <= 1'b0;
      fill_q      <= 1'b0;
      wb_addr_q   <= '0;
      fill_addr_q <= '0;
      wb_data_q   <= '0;
    end else if (accept) begin
      wb_q        <= req_wb;
      fill_q      <= req_fill;
      wb_addr_q   <= blk_align(req_wb_addr);
      fill_addr_q <= blk_align(req_fill_addr);
      wb_data_q   <= req_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                     resp_data <= '0;
    else if ((state_q == ST_FILL) && cnt_done)   resp_data <= mem_rd_data;
  end

endmodule

// File: tb/tb_blk_xfer_ctrl.sv
// Scoreboarded bench for blk_xfer_ctrl with a behavioural block memory.
module tb_blk_xfer_ctrl;
  import blk_xfer_ctrl_pkg::*;

  localparam int L = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0, req_ready;
  logic                 req_wb = 1'b0, req_fill = 1'b0;
  logic [PA_WIDTH-1:0]  req_wb_addr = '0, req_fill_addr = '0;
  logic [BLK_WIDTH-1:0] req_wb_data = '0;
  logic                 resp_valid, busy, mem_rd_en, mem_wr_en;
  logic [BLK_WIDTH-1:0] resp_data, mem_wr_data, mem_rd_data;
  logic [PA_WIDTH-1:0]  mem_addr;

  blk_xfer_ctrl #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_fill(req_fill), .req_wb_addr(req_wb_addr),
    .req_fill_addr(req_fill_addr), .req_wb_data(req_wb_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Block memory: combinational read, write on the rising edge, plus a preload port.
  logic [BLK_WIDTH-1:0] mem [0:65535];
  logic                 pre_we = 1'b0;
  logic [PA_WIDTH-1:0]  pre_addr = '0;
  logic [BLK_WIDTH-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)         mem[pre_addr] <= pre_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end
  assign mem_rd_data = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int                   at;
    logic [BLK_WIDTH-1:0] data;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [BLK_WIDTH-1:0] act, input logic [BLK_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) chk("enable_overlap", 1'b1, 1'b0);
    if (resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.at));
        chk("resp_data", resp_data, e.data);
      end
    end
  end

  logic [BLK_WIDTH-1:0] last_fill = '0;

  // Present a request, wait for acceptance, push the expected response and
  // check the memory-side sequence cycle by cycle.
  task automatic do_req(input logic wb, input logic fill,
                        input logic [PA_WIDTH-1:0] wa, input logic [PA_WIDTH-1:0] fa,
                        input logic [BLK_WIDTH-1:0] wd, input logic [BLK_WIDTH-1:0] fill_exp);
    int   acc, n, w;
    bit   ok;
    exp_t e;
    req_wb = wb; req_fill = fill; req_wb_addr = wa; req_fill_addr = fa;
    req_wb_data = wd; req_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 1'b0, 1'b1);
      req_valid = 1'b0;
      return;
    end
    w = wb ? L : 0;
    n = w + (fill ? L : 0) + 1;
    acc = cyc;
    if (fill) last_fill = fill_exp;
    e.at = acc + n; e.data = last_fill;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      chk($sformatf("wr_en_c%0d", c), mem_wr_en, wb && (c <= w));
      chk($sformatf("rd_en_c%0d", c), mem_rd_en, fill && (c > w) && (c < n));
      chk($sformatf("busy_c%0d", c), busy, 1'b1);
      if (wb && c <= w) begin
        chk("wb_addr", mem_addr, blk_align(wa));
        chk("wb_data", mem_wr_data, wd);
      end else if (fill && c < n) begin
        chk("fill_addr", mem_addr, blk_align(fa));
      end else begin
        chk("resp_addr_zero", mem_addr, '0);
      end
    end
    @(negedge clk);
    chk("ready_after", req_ready, 1'b1);
  endtask

  initial begin
    // Reset for two cycles while preloading the fill patterns.
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 16'h0040; pre_data = {8{8'hA5}};
    @(negedge clk);
    pre_addr = 16'h0080; pre_data = 64'h0;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_en", mem_rd_en, 1'b0);
    chk("rst_wr_en", mem_wr_en, 1'b0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    pre_we = 1'b0; rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 1'b1, 16'h0000, 16'h0040, 64'h0, {8{8'hA5}});
    do_req(1'b1, 1'b1, 16'h0080, 16'h0080, {8{8'h3C}}, {8{8'h3C}});
    do_req(1'b0, 1'b1, 16'h0000, 16'h0047, 64'h0, {8{8'hA5}});
    do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 64'h0, 64'h0);
    do_req(1'b1, 1'b0, 16'h00C5, 16'h0000, 64'h1122334455667788, 64'h0);
    do_req(1'b0, 1'b1, 16'h0000, 16'h00C0, 64'h0, 64'h1122334455667788);

    // Reset on the second WB cycle: no response, transfer abandoned.
    req_wb = 1'b1; req_fill = 1'b1; req_wb_addr = 16'h0100; req_fill_addr = 16'h0100;
    req_wb_data = {8{8'h5A}}; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_wb_c1_wr_en", mem_wr_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_wr_en", mem_wr_en, 1'b0);
    chk("mid_rst_rd_en", mem_rd_en, 1'b0);
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_resp_data", resp_data, '0);
    last_fill = '0;
    for (int i = 0; i < 2 * L + 2; i++) @(negedge clk);
    do_req(1'b0, 1'b1, 16'h0000, 16'h0040, 64'h0, {8{8'hA5}});

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
